uart_cmd_matcher: RTL and testbench
===================================

Name: uart_cmd_matcher

Overview:
Parametrised keyword detector on the UART receive byte stream. It watches RData/DVPulse from the UART receiver and matches up to NUM_CMD configurable keywords, each terminated by TERM_CHAR. On a match it reports which command arrived, as a per-command toggle, a one-cycle pulse and an encoded ID. It adds optional case folding and an inter-character timeout. Sits between the UART RX core and the command/LED logic on Clk50M.

Parameters:
NUM_CMD, 2, number of keywords (1..8)
MAX_LEN, 4, maximum keyword length in bytes (1..15)
KEYWORDS, 64'h706F7473_00006B6F, packed keyword bytes; byte j of keyword i is at bits [(i*MAX_LEN+j)*8 +: 8]; default kw0="ok", kw1="stop"
KW_LEN, 16'h0402, packed 8-bit lengths; length of keyword i is at bits [i*8 +: 8]; length 0 disables keyword i
TERM_CHAR, 8'd13, terminator byte (CR)
CASE_INSENS, 0, 1 = fold 'A'..'Z' to 'a'..'z' on both RData and keyword bytes before compare
TIMEOUT_CYC, 50_000_000, idle clocks after which partial matches are discarded; 0 disables the timeout

Ports:
Clk50M  in  1  system clock, 50 MHz
RstN  in  1  synchronous active-low reset
RData  in  8  received byte, valid when DVPulse=1
DVPulse  in  1  byte strobe; every cycle it is high counts as one byte
CmdTog  out  NUM_CMD  bit i inverts on each match of keyword i
CmdPulse  out  NUM_CMD  bit i high for exactly one cycle on a match of keyword i
CmdValid  out  1  high for one cycle when any keyword matches
CmdId  out  3  index of the lowest matching keyword; valid while CmdValid=1, otherwise holds its last value

Behaviour:
- Clock and reset: one clock, Clk50M. Reset is synchronous and active-low, on RstN. While RstN=0 at a rising edge, every output register and internal state goes to 0: CmdTog, CmdPulse, CmdValid, CmdId, all match indices and the timeout counter.
- Per-keyword channel: each keyword i has an index register idx[i], range 0..len[i]. Value len[i] means "keyword complete, awaiting TERM_CHAR". Channels run in parallel and do not interact.
- Byte compare: c = fold(RData). fold() is the identity when CASE_INSENS=0.
- On each DVPulse, for each enabled channel:
  - idx<len and c==fold(kw[i][idx]): idx <= idx+1.
  - idx==len and RData==TERM_CHAR: match for channel i; idx <= 0.
  - Otherwise (restart rule): idx <= (c==fold(kw[i][0])) ? 1 : 0. This is not full KMP: "stostop" still matches, "oook" matches "ok".
- TERM_CHAR arriving while idx<len is a mismatch; the restart rule applies.
- Disabled channels (len=0) hold idx=0 and never match.
- Match outputs, registered. In the cycle after the terminating DVPulse:
  - CmdPulse[i]=1 and CmdTog[i] inverts for every matching channel.
  - CmdValid=1 and CmdId = lowest matching index.
  - Latency is one clock from the DVPulse edge.
- All pulse outputs return to 0 in the next cycle unless a new match occurs. Back-to-back DVPulse cycles must be handled: a terminator on consecutive cycles gives consecutive pulses.
- Timeout: the counter clears on every DVPulse and otherwise increments, saturating at TIMEOUT_CYC. When it reaches TIMEOUT_CYC (TIMEOUT_CYC≠0), all idx <= 0. A DVPulse in the same cycle as the expiry wins: the byte is processed and the counter clears.
- Reset mid-sequence discards partial matches; CmdTog returns to 0.
- Width rules: idx width is $clog2(MAX_LEN+1). The timeout counter is 32 bits.

Test Plan:
- Defaults, bytes 'o','k',0x0D with gaps → one cycle after the 0x0D strobe: CmdPulse=2'b01, CmdValid=1, CmdId=0, CmdTog=2'b01. A second "ok\r" → CmdTog=2'b00.
- "oook\r" and "stok\r" → each gives exactly one kw0 match (CmdId=0). "stop\r" → CmdPulse=2'b10, CmdId=1. "okx\r" and "o\rk\r" → no CmdValid.
- CASE_INSENS=1, "OK\r" → kw0 match. CASE_INSENS=0, same bytes → no match.
- TIMEOUT_CYC=100: 'o','k', idle 100 clocks, 0x0D → no match. Repeat with a 99-clock idle → match.
- 'o','k', then RstN=0 for one clock, then 0x0D → no match; all outputs read 0 during and after reset.
- KEYWORDS kw0="ab", kw1="ab", then "ab\r" → CmdPulse=2'b11, CmdId=0. Separately, kw1 with KW_LEN=0 → never pulses. Back-to-back DVPulse cycles "ok\r" → single match with correct latency.

Source files
------------

// File: rtl/uart_cmd_matcher.sv
// uart_cmd_matcher: keyword detector on the UART RX byte stream.
// Each keyword has its own match index running in parallel; a completed keyword
// followed by TERM_CHAR produces a registered toggle, pulse and encoded ID.
module uart_cmd_matcher #(
   parameter int unsigned                    NUM_CMD     = 2,
   parameter int unsigned                    MAX_LEN     = 4,
   parameter logic [NUM_CMD*MAX_LEN*8-1:0]   KEYWORDS    = 64'h706F7473_00006B6F,
   parameter logic [NUM_CMD*8-1:0]           KW_LEN      = 16'h0402,
   parameter logic [7:0]                     TERM_CHAR   = 8'd13,
   parameter bit                             CASE_INSENS = 1'b0,
   parameter int unsigned                    TIMEOUT_CYC = 50_000_000
) (
   input  logic               Clk50M,
   input  logic               RstN,
   input  logic [7:0]         RData,
   input  logic               DVPulse,
   output logic [NUM_CMD-1:0] CmdTog,
   output logic [NUM_CMD-1:0] CmdPulse,
   output logic               CmdValid,
   output logic [2:0]         CmdId
);

   localparam int unsigned IW  = $clog2(MAX_LEN + 1);
   localparam int unsigned CW  = 32;
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

   // Fold upper-case ASCII to lower-case when case-insensitive matching is enabled
   function automatic logic [7:0] fold(input logic [7:0] b);
      if (CASE_INSENS && (b >= 8'h41) && (b <= 8'h5A)) begin
         return b | 8'h20;
      end
      return b;
   endfunction

   logic [IW-1:0]      idx     [NUM_CMD];
   logic [IW-1:0]      idx_nxt [NUM_CMD];
   logic [NUM_CMD-1:0] match;
   logic [2:0]         id_enc;
   logic               id_found;
   logic [CW-1:0]      tmo_cnt;
   logic               tmo_hit;
   logic [7:0]         c;
   logic [IW-1:0]      len_i;
   logic [7:0]         kw_cur;
   logic [7:0]         kw_first;

   assign c = fold(RData);

   // Partial matches expire when the idle count is about to reach the limit
   always_comb begin
      tmo_hit = 1'b0;
      if ((TMO != '0) && !DVPulse && ((tmo_cnt + CW'(1)) >= TMO)) begin
         tmo_hit = 1'b1;
      end
   end

   // Per-keyword index advance, terminator detection and restart
   always_comb begin
      idx_nxt  = idx;
      match    = '0;
      len_i    = '0;
      kw_cur   = '0;
      kw_first = '0;
      for (int unsigned i = 0; i < NUM_CMD; i++) begin
         len_i    = IW'(KW_LEN[i*8 +: 8]);
         kw_first = fold(KEYWORDS[(i*MAX_LEN)*8 +: 8]);
         kw_cur   = '0;
         for (int unsigned j = 0; j < MAX_LEN; j++) begin
            if (idx[i] == IW'(j)) begin
               kw_cur = fold(KEYWORDS[(i*MAX_LEN + j)*8 +: 8]);
            end
         end
         if (len_i == '0) begin
            idx_nxt[i] = '0;
         end else if (DVPulse) begin
            if ((idx[i] < len_i) && (c == kw_cur)) begin
               idx_nxt[i] = idx[i] + IW'(1);
            end else if ((idx[i] == len_i) && (RData == TERM_CHAR)) begin
               match[i]   = 1'b1;
               idx_nxt[i] = '0;
            end else begin
               idx_nxt[i] = (c == kw_first) ? IW'(1) : '0;
            end
         end else if (tmo_hit) begin
            idx_nxt[i] = '0;
         end
      end
   end

   // Lowest matching keyword index
   always_comb begin
      id_enc   = '0;
      id_found = 1'b0;
      for (int unsigned i = 0; i < NUM_CMD; i++) begin
         if (match[i] && !id_found) begin
            id_enc   = 3'(i);
            id_found = 1'b1;
         end
      end
   end

   // Idle counter: cleared by every byte strobe, saturates at the limit
   always_ff @(posedge Clk50M) begin
      if (!RstN) begin
         tmo_cnt <= '0;
      end else if (DVPulse) begin
         tmo_cnt <= '0;
      end else if (tmo_cnt < TMO) begin
         tmo_cnt <= tmo_cnt + CW'(1);
      end
   end

   // Match index registers
   always_ff @(posedge Clk50M) begin
      if (!RstN) begin
         for (int unsigned i = 0; i < NUM_CMD; i++) begin
            idx[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_CMD; i++) begin
            idx[i] <= idx_nxt[i];
         end
      end
   end

   // Registered match reporting; CmdId holds between matches
   always_ff @(posedge Clk50M) begin
      if (!RstN) begin
         CmdTog   <= '0;
         CmdPulse <= '0;
         CmdValid <= 1'b0;
         CmdId    <= '0;
      end else begin
         CmdTog   <= CmdTog ^ match;
         CmdPulse <= match;
         CmdValid <= |match;
         if (|match) begin
            CmdId <= id_enc;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_matcher.sv
// Directed bench for uart_cmd_matcher: one shared byte stream feeds several
// differently-parameterised instances; expectations are hand-computed.
module tb_uart_cmd_matcher;

   logic       Clk50M;
   logic       RstN;
   logic [7:0] RData;
   logic       DVPulse;

   logic [1:0] tog0, pulse0, tog1, pulse1, tog2, pulse2, tog3, pulse3, tog4, pulse4;
   logic       valid0, valid1, valid2, valid3, valid4;
   logic [2:0] id0, id1, id2, id3, id4;

   localparam logic [7:0] CR = 8'h0D;

   // u0: defaults ("ok", "stop")
   uart_cmd_matcher u0 (.Clk50M(Clk50M), .RstN(RstN), .RData(RData), .DVPulse(DVPulse),
      .CmdTog(tog0), .CmdPulse(pulse0), .CmdValid(valid0), .CmdId(id0));
   // u1: case-insensitive
   uart_cmd_matcher #(.CASE_INSENS(1'b1)) u1 (.Clk50M(Clk50M), .RstN(RstN), .RData(RData),
      .DVPulse(DVPulse), .CmdTog(tog1), .CmdPulse(pulse1), .CmdValid(valid1), .CmdId(id1));
   // u2: short timeout
   uart_cmd_matcher #(.TIMEOUT_CYC(100)) u2 (.Clk50M(Clk50M), .RstN(RstN), .RData(RData),
      .DVPulse(DVPulse), .CmdTog(tog2), .CmdPulse(pulse2), .CmdValid(valid2), .CmdId(id2));
   // u3: both keywords "ab"
   uart_cmd_matcher #(.KEYWORDS(64'h00006261_00006261), .KW_LEN(16'h0202)) u3 (.Clk50M(Clk50M),
      .RstN(RstN), .RData(RData), .DVPulse(DVPulse), .CmdTog(tog3), .CmdPulse(pulse3),
      .CmdValid(valid3), .CmdId(id3));
   // u4: keyword 1 disabled
   uart_cmd_matcher #(.KW_LEN(16'h0002)) u4 (.Clk50M(Clk50M), .RstN(RstN), .RData(RData),
      .DVPulse(DVPulse), .CmdTog(tog4), .CmdPulse(pulse4), .CmdValid(valid4), .CmdId(id4));

   initial Clk50M = 1'b0;
   always #5 Clk50M = ~Clk50M;

   typedef struct {
      logic [7:0] data;
      logic       dv;
      logic [1:0] pulse;
      logic [2:0] id;
      logic [1:0] tog;
      logic       v1;
      logic [1:0] p3;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic by(input logic [7:0] d, input logic [1:0] p, input logic [2:0] id,
                     input logic [1:0] tog, input logic v1, input logic [1:0] p3);
      vec_t v;
      v.data = d; v.dv = 1'b1; v.pulse = p; v.id = id; v.tog = tog; v.v1 = v1; v.p3 = p3;
      tbl.push_back(v);
   endtask

   task automatic gp(input logic [2:0] id, input logic [1:0] tog);
      vec_t v;
      v.data = 8'h00; v.dv = 1'b0; v.pulse = 2'b00; v.id = id; v.tog = tog; v.v1 = 1'b0;
      v.p3 = 2'b00;
      tbl.push_back(v);
   endtask

   // Drive one cycle at the falling edge, return just after the next rising edge
   task automatic cyc(input logic [7:0] d, input logic dv);
      @(negedge Clk50M);
      RData   = d;
      DVPulse = dv;
      @(posedge Clk50M);
      #1;
   endtask

   initial begin
      RstN    = 1'b0;
      RData   = 8'h00;
      DVPulse = 1'b0;

      // Table: "ok\r" twice (second back-to-back), "stop\r", "oook\r", "stok\r",
      // "okx\r", "o\rk\r", "OK\r", "stostop\r", "ab\r"
      by("o", 2'b00, 0, 2'b00, 0, 2'b00); gp(0, 2'b00);
      by("k", 2'b00, 0, 2'b00, 0, 2'b00); gp(0, 2'b00);
      by(CR,  2'b01, 0, 2'b01, 1, 2'b00); gp(0, 2'b01);
      by("o", 2'b00, 0, 2'b01, 0, 2'b00);
      by("k", 2'b00, 0, 2'b01, 0, 2'b00);
      by(CR,  2'b01, 0, 2'b00, 1, 2'b00);
      by("s", 2'b00, 0, 2'b00, 0, 2'b00);
      by("t", 2'b00, 0, 2'b00, 0, 2'b00);
      by("o", 2'b00, 0, 2'b00, 0, 2'b00);
      by("p", 2'b00, 0, 2'b00, 0, 2'b00);
      by(CR,  2'b10, 1, 2'b10, 1, 2'b00); gp(1, 2'b10);
      by("o", 2'b00, 1, 2'b10, 0, 2'b00);
      by("o", 2'b00, 1, 2'b10, 0, 2'b00);
      by("o", 2'b00, 1, 2'b10, 0, 2'b00);
      by("k", 2'b00, 1, 2'b10, 0, 2'b00);
      by(CR,  2'b01, 0, 2'b11, 1, 2'b00);
      by("s", 2'b00, 0, 2'b11, 0, 2'b00);
      by("t", 2'b00, 0, 2'b11, 0, 2'b00);
      by("o", 2'b00, 0, 2'b11, 0, 2'b00);
      by("k", 2'b00, 0, 2'b11, 0, 2'b00);
      by(CR,  2'b01, 0, 2'b10, 1, 2'b00);
      by("o", 2'b00, 0, 2'b10, 0, 2'b00);
      by("k", 2'b00, 0, 2'b10, 0, 2'b00);
      by("x", 2'b00, 0, 2'b10, 0, 2'b00);
      by(CR,  2'b00, 0, 2'b10, 0, 2'b00);
      by("o", 2'b00, 0, 2'b10, 0, 2'b00);
      by(CR,  2'b00, 0, 2'b10, 0, 2'b00);
      by("k", 2'b00, 0, 2'b10, 0, 2'b00);
      by(CR,  2'b00, 0, 2'b10, 0, 2'b00);
      by("O", 2'b00, 0, 2'b10, 0, 2'b00);
      by("K", 2'b00, 0, 2'b10, 0, 2'b00);
      by(CR,  2'b00, 0, 2'b10, 1, 2'b00);
      by("s", 2'b00, 0, 2'b10, 0, 2'b00);
      by("t", 2'b00, 0, 2'b10, 0, 2'b00);
      by("o", 2'b00, 0, 2'b10, 0, 2'b00);
      by("s", 2'b00, 0, 2'b10, 0, 2'b00);
      by("t", 2'b00, 0, 2'b10, 0, 2'b00);
      by("o", 2'b00, 0, 2'b10, 0, 2'b00);
      by("p", 2'b00, 0, 2'b10, 0, 2'b00);
      by(CR,  2'b10, 1, 2'b00, 1, 2'b00);
      by("a", 2'b00, 1, 2'b00, 0, 2'b00);
      by("b", 2'b00, 1, 2'b00, 0, 2'b00);
      by(CR,  2'b00, 1, 2'b00, 0, 2'b11); gp(1, 2'b00);

      // Reset state
      repeat (2) @(posedge Clk50M);
      #1;
      chk("reset tog",   8'(tog0),   8'h00);
      chk("reset pulse", 8'(pulse0), 8'h00);
      chk("reset valid", 8'(valid0), 8'h00);
      chk("reset id",    8'(id0),    8'h00);
      @(negedge Clk50M);
      RstN = 1'b1;

      // Table-driven vectors
      foreach (tbl[k]) begin
         cyc(tbl[k].data, tbl[k].dv);
         chk($sformatf("row%0d pulse", k),  8'(pulse0), 8'(tbl[k].pulse));
         chk($sformatf("row%0d valid", k),  8'(valid0), 8'(|tbl[k].pulse));
         chk($sformatf("row%0d id", k),     8'(id0),    8'(tbl[k].id));
         chk($sformatf("row%0d tog", k),    8'(tog0),   8'(tbl[k].tog));
         chk($sformatf("row%0d ci_valid", k), 8'(valid1), 8'(tbl[k].v1));
         chk($sformatf("row%0d ab_pulse", k), 8'(pulse3), 8'(tbl[k].p3));
         chk($sformatf("row%0d dis_pulse", k), 8'(pulse4), 8'(tbl[k].pulse & 2'b01));
      end

      // Timeout: 100 idle clocks discards the partial "ok"
      cyc("o", 1'b1);
      cyc("k", 1'b1);
      repeat (100) cyc(8'h00, 1'b0);
      cyc(CR, 1'b1);
      chk("tmo100 valid", 8'(valid2), 8'h00);
      chk("tmo100 ref valid", 8'(valid0), 8'h01);
      cyc(8'h00, 1'b0);

      // Timeout: 99 idle clocks still matches
      cyc("o", 1'b1);
      cyc("k", 1'b1);
      repeat (99) cyc(8'h00, 1'b0);
      cyc(CR, 1'b1);
      chk("tmo99 valid", 8'(valid2), 8'h01);
      chk("tmo99 pulse", 8'(pulse2), 8'h01);
      cyc(8'h00, 1'b0);
      chk("tmo99 pulse drop", 8'(valid2), 8'h00);

      // Reset mid-sequence; u0 tog 00 -> 10 on "stop\r" first
      cyc("s", 1'b1); cyc("t", 1'b1); cyc("o", 1'b1); cyc("p", 1'b1); cyc(CR, 1'b1);
      chk("pre-rst id",  8'(id0),  8'h01);
      chk("pre-rst tog", 8'(tog0), 8'h02);
      cyc("o", 1'b1);
      cyc("k", 1'b1);
      @(negedge Clk50M);
      RstN    = 1'b0;
      DVPulse = 1'b0;
      @(posedge Clk50M);
      #1;
      chk("in-rst tog",   8'(tog0),   8'h00);
      chk("in-rst pulse", 8'(pulse0), 8'h00);
      chk("in-rst valid", 8'(valid0), 8'h00);
      chk("in-rst id",    8'(id0),    8'h00);
      chk("in-rst ab tog", 8'(tog3),  8'h00);
      @(negedge Clk50M);
      RstN = 1'b1;
      cyc(CR, 1'b1);
      chk("post-rst valid", 8'(valid0), 8'h00);
      chk("post-rst tog",   8'(tog0),   8'h00);
      chk("post-rst id",    8'(id0),    8'h00);

      // Both keywords "ab": both bits pulse, lowest ID reported
      cyc("a", 1'b1); cyc("b", 1'b1); cyc(CR, 1'b1);
      chk("ab pulse", 8'(pulse3), 8'h03);
      chk("ab valid", 8'(valid3), 8'h01);
      chk("ab id",    8'(id3),    8'h00);
      chk("ab tog",   8'(tog3),   8'h03);
      chk("ab ref valid", 8'(valid0), 8'h00);
      cyc(8'h00, 1'b0);
      chk("ab pulse drop", 8'(pulse3), 8'h00);
      chk("ab valid drop", 8'(valid3), 8'h00);
      chk("ab tog hold",   8'(tog3),   8'h03);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
